// File: rtl/ga23_vram_sched.sv
// GA23 VRAM time-slot scheduler: round-robin layer tile fetches, CPU slots and a
// per-line rowscroll/rowselect table fetch sharing one synchronous VRAM port.

module ga23_vram_sched_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_scroll,
  input  logic       wr_sel,
  input  logic       enable,
  input  logic [9:0] din,
  output logic [9:0] scroll,
  output logic [9:0] sel
);
  logic [9:0] val;

  // A disabled layer still gets its slot; it just stores zero.
  assign val = enable ? din : 10'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scroll <= '0;
      sel    <= '0;
    end else begin
      if (wr_scroll) scroll <= val;
      if (wr_sel)    sel    <= val;
    end
  end
endmodule

module ga23_vram_sched #(
  parameter int                NUM_LAYERS = 4,
  parameter int                CPU_SLOTS  = 2,
  parameter int                RS_TABLES  = 2,
  parameter int                ADDR_W     = 15,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] RS_BASE    = 15'h7000,
  parameter logic [ADDR_W-1:0] RS_STRIDE  = 15'h0100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         line_start,
  input  logic [9:0]                   line,
  input  logic [NUM_LAYERS-1:0]        rs_enable,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ack,
  output logic                         busy,
  output logic [ADDR_W-1:0]            vram_addr,
  output logic [DATA_W-1:0]            vram_dout,
  output logic                         vram_we,
  input  logic [DATA_W-1:0]            vram_din,
  output logic [NUM_LAYERS-1:0]        layer_load,
  output logic [DATA_W-1:0]            tile_index,
  output logic [DATA_W-1:0]            tile_attrib,
  output logic [NUM_LAYERS*10-1:0]     rowscroll,
  output logic [NUM_LAYERS*10-1:0]     rowselect,
  output logic                         rs_active
);
  localparam int P  = 2 * (NUM_LAYERS + CPU_SLOTS);
  localparam int TW = $clog2(P);
  localparam int NE = NUM_LAYERS * RS_TABLES;
  localparam int FW = $clog2(2 * NE);

  typedef enum logic {RUN, FETCH} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cpu_req_t;

  state_t                  state, state_nx;
  logic [TW-1:0]           t, t_nx;
  logic [FW-1:0]           ft, ft_nx;
  logic [FW-1:0]           e_full;
  logic                    enter_fetch, fetch_done;
  logic                    rs_pending, cpu_req_d, issued, accept;
  logic                    in_layer, slot_first, slot_second, fetch_odd;
  cpu_req_t                req;
  logic [DATA_W-1:0]       idx_latch;
  logic [ADDR_W-1:0]       lyr_addr, rs_addr;
  logic [NUM_LAYERS-1:0]   load_oh;

  assign accept      = cpu_req & ~cpu_req_d & ~busy;
  assign in_layer    = t < TW'(2 * NUM_LAYERS);
  assign slot_first  = !in_layer && !t[0];
  assign slot_second = !in_layer && t[0];
  assign e_full      = ft >> 1;
  assign fetch_odd   = ce && (state == FETCH) && ft[0];
  // Entry index already equals tab*NUM_LAYERS+l, so it scales the stride directly.
  assign rs_addr     = RS_BASE + ADDR_W'(e_full) * RS_STRIDE
                     + ADDR_W'({~line[7], line[6:0]});

  always_comb begin
    lyr_addr = '0;
    load_oh  = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (t[TW-1:1] == (TW-1)'(i)) lyr_addr = layer_addr[i*ADDR_W +: ADDR_W];
      load_oh[i] = (t == TW'(2 * i + 2));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      t     <= '0;
      ft    <= '0;
    end else begin
      state <= state_nx;
      t     <= t_nx;
      ft    <= ft_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    t_nx        = t;
    ft_nx       = ft;
    enter_fetch = 1'b0;
    fetch_done  = 1'b0;
    if (ce) begin
      case (state)
        RUN: begin
          if (t == TW'(P - 1)) begin
            t_nx = '0;
            if (rs_pending) begin
              state_nx    = FETCH;
              enter_fetch = 1'b1;
            end
          end else begin
            t_nx = t + TW'(1);
          end
        end
        FETCH: begin
          if (ft == FW'(2 * NE - 1)) begin
            state_nx   = RUN;
            ft_nx      = '0;
            fetch_done = 1'b1;
          end else begin
            ft_nx = ft + FW'(1);
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
      busy        <= 1'b0;
      vram_addr   <= '0;
      vram_dout   <= '0;
      vram_we     <= 1'b0;
      layer_load  <= '0;
      tile_index  <= '0;
      tile_attrib <= '0;
      rs_active   <= 1'b0;
      rs_pending  <= 1'b0;
      cpu_req_d   <= 1'b0;
      issued      <= 1'b0;
      req         <= '0;
      idx_latch   <= '0;
    end else begin
      layer_load <= '0;
      cpu_ack    <= 1'b0;
      vram_we    <= 1'b0;
      cpu_req_d  <= cpu_req;

      if (accept) begin
        req  <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        busy <= 1'b1;
      end

      // A line_start landing on the wrap tick wins over the clear: one-period delay.
      if (line_start)       rs_pending <= 1'b1;
      else if (enter_fetch) rs_pending <= 1'b0;

      if (enter_fetch)     rs_active <= 1'b1;
      else if (fetch_done) rs_active <= 1'b0;

      if (ce) begin
        if (state == RUN) begin
          if (in_layer) begin
            if (!t[0]) begin
              vram_addr <= {lyr_addr[ADDR_W-1:1], 1'b0};
            end else begin
              idx_latch <= vram_din;
              vram_addr <= {lyr_addr[ADDR_W-1:1], 1'b1};
            end
          end
          if (|load_oh) begin
            tile_index  <= idx_latch;
            tile_attrib <= vram_din;
            layer_load  <= load_oh;
          end
          // Only a request already held at the slot's first tick is served there.
          if (slot_first) begin
            issued <= busy;
            if (busy) begin
              vram_addr <= req.addr;
              vram_dout <= req.wdata;
              vram_we   <= req.we;
            end
          end
          if (slot_second && issued) begin
            cpu_rdata <= vram_din;
            cpu_ack   <= 1'b1;
            busy      <= 1'b0;
            issued    <= 1'b0;
          end
        end else if (!ft[0]) begin
          vram_addr <= rs_addr;
        end
      end
    end
  end

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_lane
    logic wr_scroll, wr_sel;
    assign wr_scroll = fetch_odd && (e_full == FW'(l));
    assign wr_sel    = (RS_TABLES > 1) && fetch_odd && (e_full == FW'(NUM_LAYERS + l));

    ga23_vram_sched_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .wr_scroll (wr_scroll),
      .wr_sel    (wr_sel),
      .enable    (rs_enable[l]),
      .din       (vram_din[9:0]),
      .scroll    (rowscroll[l*10 +: 10]),
      .sel       (rowselect[l*10 +: 10])
    );
  end
endmodule

// File: tb/tb_ga23_vram_sched.sv
// Directed bench for ga23_vram_sched: async-read VRAM model, scoreboard queues for
// tile loads, CPU reads and table fetches, immediate assertions at each check.

module tb_ga23_vram_sched;
  localparam int NL = 4;
  localparam int AW = 15;
  localparam int DW = 16;

  logic              clk = 1'b0, rst = 1'b1, ce = 1'b1, line_start = 1'b0;
  logic [9:0]        line = '0;
  logic [NL-1:0]     rs_enable = '0;
  logic [NL*AW-1:0]  layer_addr = '0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0]     cpu_addr = '0;
  logic [DW-1:0]     cpu_wdata = '0;
  logic [DW-1:0]     cpu_rdata, vram_dout, vram_din, tile_index, tile_attrib;
  logic              cpu_ack, busy, vram_we, rs_active;
  logic [AW-1:0]     vram_addr;
  logic [NL-1:0]     layer_load;
  logic [NL*10-1:0]  rowscroll, rowselect;

  int passed = 0, total = 0;
  bit slow = 1'b0;
  int ph = 0;
  int nt, last_t;

  typedef struct {
    int          layer;
    logic [15:0] idx;
    logic [15:0] attr;
    int          tick;
  } load_exp_t;

  load_exp_t   load_q[$];
  logic [15:0] rd_q[$];
  logic [39:0] rs_q[$];
  logic [39:0] sel_q[$];
  logic [15:0] mem [0:32767];

  ga23_vram_sched dut (
    .clk(clk), .reset(rst), .ce(ce), .line_start(line_start), .line(line),
    .rs_enable(rs_enable), .layer_addr(layer_addr), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .busy(busy), .vram_addr(vram_addr), .vram_dout(vram_dout), .vram_we(vram_we),
    .vram_din(vram_din), .layer_load(layer_load), .tile_index(tile_index),
    .tile_attrib(tile_attrib), .rowscroll(rowscroll), .rowselect(rowselect),
    .rs_active(rs_active)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] vinit(input int a);
    case (a)
      'h1234:  return 16'hAAAA;
      'h1235:  return 16'h5555;
      'h7085:  return 16'h0011;
      'h7585:  return 16'h03FF;
      default: return 16'(a) ^ 16'h3C3C;
    endcase
  endfunction

  initial for (int i = 0; i < 32768; i++) mem[i] <= vinit(i);
  always @(posedge clk) if (vram_we) mem[vram_addr] <= vram_dout;
  assign vram_din = mem[vram_addr];

  initial begin
    forever begin
      @(negedge clk);
      ph = (ph == 2) ? 0 : ph + 1;
      ce = slow ? (ph == 0) : 1'b1;
    end
  end

  // Tick executed by the most recent ce edge (valid while no table fetch intervenes).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nt     <= 0;
      last_t <= 0;
    end else if (ce) begin
      last_t <= nt;
      nt     <= (nt == 11) ? 0 : nt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 1'b0;
    line_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_ls();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  function automatic logic [39:0] exp_tab(input int tab, input logic [9:0] ln,
                                          input logic [3:0] en);
    logic [39:0] r;
    logic [15:0] w;
    int a;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      a = ('h7000 + (tab * NL + l) * 'h100 + int'({~ln[7], ln[6:0]})) & 'h7FFF;
      w = vinit(a);
      r[l*10 +: 10] = en[l] ? w[9:0] : 10'd0;
    end
    return r;
  endfunction

  task automatic push_load(input int l, input int a, input int tick);
    load_exp_t e;
    e.layer = l;
    e.idx   = vinit(a & 'h7FFE);
    e.attr  = vinit(a | 1);
    e.tick  = tick;
    load_q.push_back(e);
  endtask

  task automatic check_load(input int budget);
    load_exp_t e;
    logic [NL-1:0] oh;
    int n;
    e = load_q[0];
    n = 0;
    do begin @(negedge clk); n++; end
    while (layer_load[e.layer] !== 1'b1 && n < budget);
    chk($sformatf("load_seen_l%0d", e.layer), layer_load[e.layer], 1);
    if (layer_load[e.layer] === 1'b1) begin
      e = load_q.pop_front();
      oh = '0;
      oh[e.layer] = 1'b1;
      chk($sformatf("load_vec_l%0d", e.layer), layer_load, oh);
      chk($sformatf("tile_index_l%0d", e.layer), tile_index, e.idx);
      chk($sformatf("tile_attrib_l%0d", e.layer), tile_attrib, e.attr);
      chk($sformatf("load_tick_l%0d", e.layer), last_t, e.tick);
    end
  endtask

  // data is the write data for writes and the expected read data for reads.
  task automatic cpu_op(input logic we, input logic [14:0] a, input logic [15:0] data,
                        input bit hold, input int we_tick, input int ack_tick,
                        input int budget);
    int n, we_cnt, we_t, busy_drop;
    logic [14:0] wa;
    logic [15:0] wd;
    if (!we) rd_q.push_back(data);
    cpu_we = we; cpu_addr = a; cpu_wdata = data; cpu_req = 1'b1;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    if (!hold) cpu_req = 1'b0;
    n = 0; we_cnt = 0; we_t = -1; busy_drop = 0; wa = '0; wd = '0;
    while (cpu_ack !== 1'b1 && n < budget) begin
      if (vram_we) begin we_cnt++; we_t = last_t; wa = vram_addr; wd = vram_dout; end
      if (!busy) busy_drop++;
      @(negedge clk);
      n++;
    end
    chk("ack_seen", cpu_ack, 1);
    if (cpu_ack === 1'b1) begin
      chk("busy_clear_at_ack", busy, 0);
      chk("ack_tick", last_t, ack_tick);
      if (!we) chk("cpu_rdata", cpu_rdata, rd_q.pop_front());
    end
    chk("busy_held", busy_drop, 0);
    chk("vram_we_count", we_cnt, we ? 1 : 0);
    if (we && we_cnt == 1) begin
      chk("vram_we_tick", we_t, we_tick);
      chk("vram_we_addr", wa, a);
      chk("vram_we_data", wd, data);
    end
  endtask

  task automatic wait_rs(input logic level, input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (rs_active !== level && n < budget);
    chk($sformatf("rs_active_to_%0d", level), rs_active, level);
  endtask

  initial begin
    int len, ll, wc, lows, acks, busys;

    layer_addr = {15'h7FFE, 15'h1234, 15'h0403, 15'h0200};

    // Reset state
    @(negedge clk);
    chk("reset_outputs", |{cpu_rdata, cpu_ack, busy, vram_addr, vram_dout, vram_we,
        layer_load, tile_index, tile_attrib, rowscroll, rowselect, rs_active}, 0);

    // T1: one period of tile fetches
    do_reset();
    push_load(0, 'h0200, 2);
    push_load(1, 'h0403, 4);
    push_load(2, 'h1234, 6);
    push_load(3, 'h7FFE, 8);
    for (int k = 0; k < NL; k++) check_load(40);

    // T2: write then read; the read is accepted during slot 1's first tick
    do_reset();
    cpu_op(1'b1, 15'h0100, 16'hBEEF, 1'b0, 8, 9, 60);
    cpu_op(1'b0, 15'h0100, 16'hBEEF, 1'b0, -1, 9, 60);

    // T3: table fetch
    do_reset();
    rs_enable = 4'b1011;
    line = 10'h005;
    rs_q.push_back(exp_tab(0, 10'h005, 4'b1011));
    sel_q.push_back(exp_tab(1, 10'h005, 4'b1011));
    pulse_ls();
    wait_rs(1'b1, 40);
    len = 0; ll = 0; wc = 0;
    while (rs_active === 1'b1 && len < 40) begin
      if (layer_load != 0) ll++;
      if (vram_we) wc++;
      len++;
      @(negedge clk);
    end
    chk("rs_active_len", len, 16);
    chk("no_load_in_fetch", ll, 0);
    chk("no_we_in_fetch", wc, 0);
    chk("rowscroll_all", rowscroll, rs_q.pop_front());
    chk("rowselect_all", rowselect, sel_q.pop_front());
    chk("rowscroll0", rowscroll[9:0], 10'h011);
    chk("rowselect1", rowselect[19:10], 10'h3FF);
    chk("layer2_off", {rowscroll[29:20], rowselect[29:20]}, 0);

    // T4: line_start during a fetch re-arms for the following wrap
    pulse_ls();
    wait_rs(1'b1, 40);
    repeat (2) @(negedge clk);
    pulse_ls();
    wait_rs(1'b0, 40);
    line = 10'h086;
    rs_enable = 4'b0110;
    rs_q.push_back(exp_tab(0, 10'h086, 4'b0110));
    sel_q.push_back(exp_tab(1, 10'h086, 4'b0110));
    lows = 0;
    do begin @(negedge clk); if (rs_active !== 1'b1) lows++; end
    while (rs_active !== 1'b1 && lows < 40);
    chk("refetch_gap", lows, 11);
    wait_rs(1'b0, 40);
    chk("refetch_rowscroll", rowscroll, rs_q.pop_front());
    chk("refetch_rowselect", rowselect, sel_q.pop_front());

    // T5: ce at one third rate, request held high
    slow = 1'b1;
    do_reset();
    push_load(2, 'h1234, 6);
    check_load(150);
    @(negedge clk);
    chk("load_pulse_1clk", layer_load, 0);
    cpu_op(1'b0, 15'h0100, 16'hBEEF, 1'b1, -1, 9, 150);
    acks = 0; busys = 0;
    repeat (80) begin
      @(negedge clk);
      if (cpu_ack) acks++;
      if (busy) busys++;
    end
    chk("held_req_acks", acks, 0);
    chk("held_req_busy", busys, 0);
    cpu_req = 1'b0;
    slow = 1'b0;

    // T6: reset while busy and fetching
    do_reset();
    pulse_ls();
    wait_rs(1'b1, 40);
    cpu_we = 1'b0; cpu_addr = 15'h0100; cpu_req = 1'b1;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_active", rs_active, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_active", rs_active, 0);
    chk("async_rst_addr", vram_addr, 0);
    chk("async_rst_all", |{cpu_rdata, cpu_ack, busy, vram_addr, vram_dout, vram_we,
        layer_load, tile_index, tile_attrib, rowscroll, rowselect, rs_active}, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (40) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("no_ack_after_rst", acks, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
